adc_spi_cfg: RTL and testbench

// Initiator for the ADC serial control interface (adc_scs/adc_sclk/adc_sdi/adc_sdo).

---
 rtl/adc_spi_cfg.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_spi_cfg.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_cfg.sv
// adc_spi_cfg: initiator for the ADC serial control port.
// Accepts one register read/write command at a time, shifts a 24-bit frame
// MSB-first on adc_sdi and returns the 16 data bits read back on adc_sdo.
// Every ADC pin comes straight from a flop. cmd_ready and busy are decoded
// from the state register only.
`timescale 1ns/1ps

module adc_spi_cfg #(
    parameter int CLK_DIV = 4,   // adc_sclk half-period in clk cycles (>= 2)
    parameter int SCS_GAP = 2    // adc_scs-high time between frames, in half-periods (>= 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        adc_scs,
    output logic        adc_sclk,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    // Last clk count of one sclk half-period.
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    // The GAP state is one cycle shorter than the scs-high time, because the
    // IDLE cycle that accepts the next command also counts as scs-high time.
    localparam logic [15:0] GAP_LAST  = 16'(SCS_GAP * CLK_DIV - 2);
    // The sclk edge counter counts edges already driven, from 1 to 48.
    localparam logic [5:0]  EDGE_LAST = 6'd48;  // fall 24 has been driven
    localparam logic [5:0]  SDI_LIMIT = 6'd46;  // falls 1..23 load the next sdi bit
    localparam logic [5:0]  CAP_FIRST = 6'd16;  // the next rise is rise 9

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Frame layout: rw, three zero bits, address, then write data (zero on reads).
    function automatic logic [23:0] build_frame(input logic rw, input logic [3:0] addr,
                                                input logic [15:0] wdata);
        build_frame = {rw, 3'b000, addr, (rw ? 16'h0000 : wdata)};
    endfunction

    state_t       state_r;
    state_t       state_nxt_s;
    logic         accept_s;
    logic         hp_end_s;
    logic         gap_end_s;
    logic         shift_done_s;
    logic [23:0]  frame_s;

    logic [15:0]  div_cnt_r;
    logic [5:0]   edge_cnt_r;
    logic [22:0]  shift_r;
    logic         rw_r;
    logic [15:0]  rdata_sh_r;
    logic         adc_scs_r;
    logic         adc_sclk_r;
    logic         adc_sdi_r;
    logic         rsp_valid_r;
    logic [15:0]  rsp_rdata_r;

    assign hp_end_s     = (div_cnt_r == DIV_LAST);
    assign gap_end_s    = (div_cnt_r == GAP_LAST);
    assign shift_done_s = (edge_cnt_r == EDGE_LAST);
    assign frame_s      = build_frame(cmd_rw, cmd_addr, cmd_wdata);

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign adc_scs   = adc_scs_r;
    assign adc_sclk  = adc_sclk_r;
    assign adc_sdi   = adc_sdi_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and the command accept strobe.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (hp_end_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (hp_end_s && shift_done_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (hp_end_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: timing counters, pin drivers, read capture and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r   <= 16'h0000;
            edge_cnt_r  <= 6'd0;
            shift_r     <= 23'h000000;
            rw_r        <= 1'b0;
            rdata_sh_r  <= 16'h0000;
            adc_scs_r   <= 1'b1;
            adc_sclk_r  <= 1'b0;
            adc_sdi_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 16'h0000;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    div_cnt_r <= 16'h0000;
                    if (accept_s) begin
                        adc_scs_r  <= 1'b0;
                        adc_sdi_r  <= frame_s[23];
                        shift_r    <= frame_s[22:0];
                        rw_r       <= cmd_rw;
                        rdata_sh_r <= 16'h0000;
                        edge_cnt_r <= 6'd0;
                    end
                end
                ST_SETUP: begin
                    if (hp_end_s) begin
                        div_cnt_r  <= 16'h0000;
                        adc_sclk_r <= 1'b1;           // sclk rise 1
                        edge_cnt_r <= 6'd1;
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'h0001;
                    end
                end
                ST_SHIFT: begin
                    if (hp_end_s) begin
                        div_cnt_r <= 16'h0000;
                        if (!shift_done_s) begin
                            adc_sclk_r <= ~adc_sclk_r;
                            edge_cnt_r <= edge_cnt_r + 6'd1;
                            // Falling edge: present the next frame bit (falls 1..23).
                            if (adc_sclk_r && (edge_cnt_r < SDI_LIMIT)) begin
                                adc_sdi_r <= shift_r[22];
                                shift_r   <= {shift_r[21:0], 1'b0};
                            end
                            // Rising edge 9..24 of a read: sample the data phase.
                            if (!adc_sclk_r && rw_r && (edge_cnt_r >= CAP_FIRST)) begin
                                rdata_sh_r <= {rdata_sh_r[14:0], adc_sdo};
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'h0001;
                    end
                end
                ST_HOLD: begin
                    if (hp_end_s) begin
                        div_cnt_r   <= 16'h0000;
                        adc_scs_r   <= 1'b1;
                        adc_sdi_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= rw_r ? rdata_sh_r : 16'h0000;
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'h0001;
                    end
                end
                ST_GAP: begin
                    if (gap_end_s) begin
                        div_cnt_r <= 16'h0000;
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'h0001;
                    end
                end
                default: begin
                    div_cnt_r <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_cfg.sv
// Testbench for adc_spi_cfg: table of single frames plus directed sequences
// for back-to-back commands, mid-frame reset, busy-time commands and the
// minimum clock divider.
`timescale 1ns/1ps

module tb_adc_spi_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: default parameters.
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy, adc_scs, adc_sclk, adc_sdi;
    logic        adc_sdo = 1'b0;

    // DUT 1: CLK_DIV=2, SCS_GAP=1.
    logic        cmd_valid1, cmd_ready1;
    logic        rsp_valid1;
    logic [15:0] rsp_rdata1;
    logic        busy1, adc_scs1, adc_sclk1, adc_sdi1;
    logic        adc_sdo1;

    adc_spi_cfg dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .adc_scs(adc_scs), .adc_sclk(adc_sclk), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
    );

    adc_spi_cfg #(.CLK_DIV(2), .SCS_GAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_rw(1'b0), .cmd_addr(4'h9), .cmd_wdata(16'h0F0F),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
        .adc_scs(adc_scs1), .adc_sclk(adc_sclk1), .adc_sdi(adc_sdi1), .adc_sdo(adc_sdo1)
    );

    int checks = 0;
    int failures = 0;

    // ADC model / monitor state for DUT 0 (updated on the falling clk edge).
    logic [15:0] sdo_word = 16'h0000;
    logic        scs_prev = 1'b1, sclk_prev = 1'b0;
    logic [23:0] cap = 24'h0, last_frame = 24'h0;
    int cyc = 0, run = 0, scs_low_last = 0, rise_cnt = 0, fall_cnt = 0, last_rises = 0;
    int scs_fall_cnt = 0, scs_fall_cyc = 0, scs_rise_cyc = 0;
    int rsp_cnt = 0, ready_viol = 0;
    logic [15:0] last_rdata = 16'h0;

    // Monitor for DUT 0: collects sdi at each sclk rise, drives sdo after falls 8..23.
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        scs_prev  <= adc_scs;
        sclk_prev <= adc_sclk;
        if (scs_prev && !adc_scs) begin
            run          <= 1;
            rise_cnt     <= 0;
            fall_cnt     <= 0;
            cap          <= 24'h0;
            adc_sdo      <= 1'b0;
            scs_fall_cnt <= scs_fall_cnt + 1;
            scs_fall_cyc <= cyc;
        end else if (!adc_scs) begin
            run <= run + 1;
            if (!sclk_prev && adc_sclk) begin
                cap      <= {cap[22:0], adc_sdi};
                rise_cnt <= rise_cnt + 1;
            end
            if (sclk_prev && !adc_sclk) begin
                fall_cnt <= fall_cnt + 1;
                if (fall_cnt >= 7 && fall_cnt <= 22) adc_sdo <= sdo_word[22 - fall_cnt];
            end
            if (cmd_ready) ready_viol <= ready_viol + 1;
        end else if (!scs_prev) begin
            scs_low_last <= run;
            last_frame   <= cap;
            last_rises   <= rise_cnt;
            scs_rise_cyc <= cyc;
        end
        if (rsp_valid) begin
            rsp_cnt    <= rsp_cnt + 1;
            last_rdata <= rsp_rdata;
        end
    end

    // Monitor state for DUT 1.
    logic        scs1_prev = 1'b1, sclk1_prev = 1'b0;
    logic [23:0] cap1 = 24'h0, frame1_last = 24'h0;
    int cyc1 = 0, run1 = 0, low1_last = 0, gap_run1 = 0, gap1_last = 0;
    int rise1_cnt = 0, r1_cyc = 0, r2_cyc = 0, fall1_cnt = 0, rsp1_cnt = 0;
    logic [15:0] rdata1_last = 16'hFFFF;

    // Monitor for DUT 1: scs low time, sclk period, scs gap, frame contents.
    always @(negedge clk) begin
        cyc1       <= cyc1 + 1;
        scs1_prev  <= adc_scs1;
        sclk1_prev <= adc_sclk1;
        adc_sdo1   <= 1'b0;
        if (scs1_prev && !adc_scs1) begin
            run1      <= 1;
            rise1_cnt <= 0;
            cap1      <= 24'h0;
            gap1_last <= gap_run1;
            fall1_cnt <= fall1_cnt + 1;
        end else if (!adc_scs1) begin
            run1 <= run1 + 1;
            if (!sclk1_prev && adc_sclk1) begin
                cap1      <= {cap1[22:0], adc_sdi1};
                rise1_cnt <= rise1_cnt + 1;
                if (rise1_cnt == 0) r1_cyc <= cyc1;
                if (rise1_cnt == 1) r2_cyc <= cyc1;
            end
        end else begin
            if (!scs1_prev) begin
                low1_last   <= run1;
                frame1_last <= cap1;
                gap_run1    <= 1;
            end else begin
                gap_run1 <= gap_run1 + 1;
            end
        end
        if (rsp_valid1) begin
            rsp1_cnt    <= rsp1_cnt + 1;
            rdata1_last <= rsp_rdata1;
        end
    end

    typedef struct {
        logic        rw;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] sdo;
        logic [23:0] exp_frame;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One step: just past the falling edge, after the monitors have updated.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int target, input string nm);
        int n = 0;
        while (rsp_cnt < target && n < 3000) begin tick(); n++; end
        check({nm, "_rsp_seen"}, 32'(rsp_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!cmd_ready && n < 3000) begin tick(); n++; end
        check({nm, "_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic issue(input logic rw, input logic [3:0] a, input logic [15:0] d);
        cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_addr = ~a; cmd_wdata = ~d;
    endtask

    task automatic run_one(input string nm, input vec_t v);
        int r0;
        sdo_word = v.sdo;
        r0 = rsp_cnt;
        issue(v.rw, v.addr, v.wdata);
        wait_rsp(r0 + 1, nm);
        wait_idle(nm);
        check({nm, "_frame"}, 32'(last_frame), 32'(v.exp_frame));
        check({nm, "_rises"}, 32'(last_rises), 32'd24);
        check({nm, "_scs_low"}, 32'(scs_low_last), 32'd200);
        check({nm, "_rsp_count"}, 32'(rsp_cnt - r0), 32'd1);
        check({nm, "_rdata"}, 32'(last_rdata), 32'(v.exp_rdata));
    endtask

    initial begin
        int r0, f0, n;
        vec_t v;
        vecs[0] = '{1'b0, 4'h3, 16'hA5C3, 16'h0000, 24'h03A5C3, 16'h0000};
        vecs[1] = '{1'b1, 4'hD, 16'h9999, 16'h1234, 24'h8D0000, 16'h1234};
        vecs[2] = '{1'b0, 4'hF, 16'hFFFF, 16'h0000, 24'h0FFFFF, 16'h0000};
        vecs[3] = '{1'b0, 4'h0, 16'h0001, 16'h0000, 24'h000001, 16'h0000};
        vecs[4] = '{1'b1, 4'h0, 16'h0000, 16'hFFFF, 24'h800000, 16'hFFFF};
        vecs[5] = '{1'b1, 4'h7, 16'h0000, 16'h8001, 24'h870000, 16'h8001};
        vecs[6] = '{1'b0, 4'h5, 16'h1234, 16'hBEEF, 24'h051234, 16'h0000};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 4'h0;
        cmd_wdata = 16'h0000; cmd_valid1 = 1'b0;
        repeat (3) tick();
        check("rst_scs", 32'(adc_scs), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd0);
        check("rst_sdi", 32'(adc_sdi), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(cmd_ready), 32'd1);

        // Single frames from the table.
        for (int i = 0; i < 7; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i]);
        end

        // cmd_valid held across two frames: second accept on the first IDLE cycle.
        sdo_word = 16'hCAFE;
        r0 = rsp_cnt; f0 = scs_fall_cnt;
        cmd_rw = 1'b0; cmd_addr = 4'h1; cmd_wdata = 16'h1111; cmd_valid = 1'b1;
        tick();
        cmd_rw = 1'b1; cmd_addr = 4'h2; cmd_wdata = 16'h7777;
        wait_rsp(r0 + 1, "b2b_a");
        check("b2b_frame_a", 32'(last_frame), 32'h00011111);
        check("b2b_rdata_a", 32'(last_rdata), 32'h0);
        n = 0;
        while (scs_fall_cnt < f0 + 2 && n < 100) begin tick(); n++; end
        cmd_valid = 1'b0;
        check("b2b_second_fall", 32'(scs_fall_cnt - f0), 32'd2);
        check("b2b_gap_clks", 32'(scs_fall_cyc - scs_rise_cyc), 32'd8);
        wait_rsp(r0 + 2, "b2b_b");
        wait_idle("b2b");
        check("b2b_frame_b", 32'(last_frame), 32'h00820000);
        check("b2b_rdata_b", 32'(last_rdata), 32'hCAFE);
        check("ready_low_in_frames", 32'(ready_viol), 32'd0);

        // Reset at sclk rise 10: pins idle at once, no response, next frame clean.
        sdo_word = 16'h0000;
        r0 = rsp_cnt;
        issue(1'b0, 4'hC, 16'h3C3C);
        n = 0;
        while (rise_cnt < 10 && n < 500) begin tick(); n++; end
        check("rst_mid_reached_rise10", 32'(rise_cnt), 32'd10);
        rst_n = 1'b0;
        #1;
        check("rst_mid_scs", 32'(adc_scs), 32'd1);
        check("rst_mid_sclk", 32'(adc_sclk), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        v = '{1'b0, 4'h2, 16'hBEEF, 16'h0000, 24'h02BEEF, 16'h0000};
        run_one("after_rst", v);

        // Command offered while busy: ignored, frame in flight unchanged.
        r0 = rsp_cnt; f0 = scs_fall_cnt;
        issue(1'b0, 4'h6, 16'h5A5A);
        repeat (30) tick();
        cmd_rw = 1'b1; cmd_addr = 4'h9; cmd_wdata = 16'hFFFF; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_rsp(r0 + 1, "busy_cmd");
        wait_idle("busy_cmd");
        repeat (20) tick();
        check("busy_cmd_frame", 32'(last_frame), 32'h00065A5A);
        check("busy_cmd_frames", 32'(scs_fall_cnt - f0), 32'd1);
        check("busy_cmd_rsps", 32'(rsp_cnt - r0), 32'd1);

        // Minimum divider and gap on DUT 1, two frames back to back.
        cmd_valid1 = 1'b1;
        n = 0;
        while (fall1_cnt < 2 && n < 500) begin tick(); n++; end
        cmd_valid1 = 1'b0;
        n = 0;
        while (rsp1_cnt < 2 && n < 500) begin tick(); n++; end
        check("div2_rsps", 32'(rsp1_cnt), 32'd2);
        check("div2_scs_low", 32'(low1_last), 32'd100);
        check("div2_sclk_period", 32'(r2_cyc - r1_cyc), 32'd4);
        check("div2_gap", 32'(gap1_last), 32'd2);
        check("div2_frame", 32'(frame1_last), 32'h00090F0F);
        check("div2_rdata", 32'(rdata1_last), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
